// File: rtl/pipemem_pkg.sv
// Shared encodings and lane helpers for the pipeline MEM stage and its I/O window.
package pipemem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [3:0] STATUS_IDX = 4'd15;
   localparam int         IO_WIN_BIT = 6;
   localparam logic       IO_WIN_OUT = 1'b0;
   localparam logic       IO_WIN_IN  = 1'b1;

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a10);
      case (size)
         SZ_BYTE: return 4'b0001 << a10;
         SZ_HALF: return a10[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a10);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return a10[0];
         default: return a10 != 2'b00;
      endcase
   endfunction

   // Replicate the right-aligned store data so it appears in whichever lane is enabled.
   function automatic logic [31:0] store_replicate(input logic [31:0] d, input logic [1:0] size);
      case (size)
         SZ_BYTE: return {4{d[7:0]}};
         SZ_HALF: return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] a10,
                                               input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      case (a10)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = a10[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/pipemem_mmio_io_sync_detect.sv
// Two-flop synchroniser for one 32-bit input port, plus a history stage to flag value changes.
module io_sync_detect (
   input  logic        clock,
   input  logic        clrn,
   input  logic [31:0] pin_i,
   output logic [31:0] sync_o,
   output logic        change_o
);

   logic [31:0] s1_q, s2_q, s3_q;

   always_ff @(posedge clock) begin
      if (!clrn) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= pin_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign sync_o   = s2_q;
   assign change_o = (s2_q != s3_q);

endmodule

// File: rtl/pipemem_mmio.sv
// MEM stage: byte-lane data RAM with registered read, plus output registers, synchronised
// input ports and sticky change flags mapped into an I/O window.
module pipemem_mmio
   import pipemem_pkg::*;
#(
   parameter int DMEM_AW = 5,
   parameter int N_OUT   = 2,
   parameter int N_IN    = 2,
   parameter int IO_BIT  = 7
) (
   input  logic                  clock,
   input  logic                  clrn,
   input  logic                  mwmem,
   input  logic                  mrmem,
   input  logic [1:0]            msize,
   input  logic                  munsigned,
   input  logic [31:0]           mAlu,
   input  logic [31:0]           mB,
   output logic [31:0]           wmo,
   output logic                  misalign,
   output logic [32*N_OUT-1:0]   out_port,
   output logic [N_OUT-1:0]      out_strobe,
   input  logic [32*N_IN-1:0]    in_port,
   output logic                  in_irq
);

   logic                io_sel, win_in;
   logic [3:0]          idx;
   logic [1:0]          a10;
   logic [DMEM_AW-1:0]  ram_idx;
   logic                acc_mis, st_ok, ld_ok, status_rd;
   logic [3:0]          be;
   logic [31:0]         wdata;
   logic                unused_addr;

   assign io_sel      = mAlu[IO_BIT];
   assign win_in      = mAlu[IO_WIN_BIT];
   assign idx         = mAlu[5:2];
   assign a10         = mAlu[1:0];
   assign ram_idx     = mAlu[DMEM_AW+1:2];
   assign unused_addr = ^mAlu;

   assign acc_mis   = (mwmem | mrmem) & is_misaligned(msize, a10);
   assign st_ok     = mwmem & ~acc_mis;
   assign ld_ok     = mrmem & ~mwmem & ~acc_mis;
   assign status_rd = ld_ok & io_sel & (win_in == IO_WIN_IN) & (idx == STATUS_IDX);
   assign be        = byte_en(msize, a10);
   assign wdata     = store_replicate(mB, msize);

   // Data RAM: plain array, byte-enable write and registered read so it maps to block RAM.
   logic [31:0] mem [0:(1<<DMEM_AW)-1];
   logic [31:0] ram_rd_q;

   always_ff @(posedge clock) begin
      if (clrn && st_ok && !io_sel) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      ram_rd_q <= mem[ram_idx];
   end

   logic [31:0]      out_q [N_OUT];
   logic [N_OUT-1:0] out_we, strobe_q;

   always_comb begin
      out_we = '0;
      for (int k = 0; k < N_OUT; k++) begin
         if (st_ok && io_sel && (win_in == IO_WIN_OUT) && idx == 4'(k)) out_we[k] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!clrn) begin
         strobe_q <= '0;
         for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      end else begin
         strobe_q <= out_we;
         for (int k = 0; k < N_OUT; k++) begin
            for (int b = 0; b < 4; b++) begin
               if (out_we[k] && be[b]) out_q[k][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_OUT; gi++) begin : g_out
         assign out_port[32*gi +: 32] = out_q[gi];
      end
   endgenerate

   logic [31:0]     in_sync [N_IN];
   logic [N_IN-1:0] change, flag_q, flag_d;

   generate
      for (gi = 0; gi < N_IN; gi++) begin : g_in
         io_sync_detect u_sync (
            .clock    (clock),
            .clrn     (clrn),
            .pin_i    (in_port[32*gi +: 32]),
            .sync_o   (in_sync[gi]),
            .change_o (change[gi])
         );
      end
   endgenerate

   // A change seen in the same cycle as a STATUS read wins over the clear.
   assign flag_d = change | (flag_q & ~{N_IN{status_rd}});

   logic [31:0] io_rd;

   always_comb begin
      io_rd = '0;
      if (win_in == IO_WIN_OUT) begin
         for (int k = 0; k < N_OUT; k++) begin
            if (idx == 4'(k)) io_rd = out_q[k];
         end
      end else begin
         for (int k = 0; k < N_IN; k++) begin
            if (idx == 4'(k)) io_rd = in_sync[k];
         end
         if (idx == STATUS_IDX) io_rd = 32'(flag_q);
      end
   end

   logic        ld_v_q, io_src_q, uns_q, mis_q, irq_q;
   logic [1:0]  a10_q, size_q;
   logic [31:0] io_rd_q;

   always_ff @(posedge clock) begin
      if (!clrn) begin
         ld_v_q   <= 1'b0;
         io_src_q <= 1'b0;
         uns_q    <= 1'b0;
         mis_q    <= 1'b0;
         irq_q    <= 1'b0;
         a10_q    <= '0;
         size_q   <= '0;
         io_rd_q  <= '0;
         flag_q   <= '0;
      end else begin
         ld_v_q   <= ld_ok;
         io_src_q <= io_sel;
         uns_q    <= munsigned;
         mis_q    <= acc_mis;
         irq_q    <= |flag_d;
         a10_q    <= a10;
         size_q   <= msize;
         io_rd_q  <= io_rd;
         flag_q   <= flag_d;
      end
   end

   always_comb begin
      wmo = '0;
      if (ld_v_q) wmo = load_extend(io_src_q ? io_rd_q : ram_rd_q, a10_q, size_q, uns_q);
   end

   assign misalign   = mis_q;
   assign out_strobe = strobe_q;
   assign in_irq     = irq_q;

endmodule

// File: tb/tb_pipemem_mmio.sv
// Directed bench for pipemem_mmio: RAM sizes/extension, alignment, I/O window, sync flags, reset.
module tb_pipemem_mmio;

   localparam logic [1:0] B = 2'd0;
   localparam logic [1:0] H = 2'd1;
   localparam logic [1:0] W = 2'd2;

   logic        clock = 1'b0;
   logic        clrn, mwmem, mrmem, munsigned, misalign, in_irq;
   logic [1:0]  msize, out_strobe;
   logic [31:0] mAlu, mB, wmo;
   logic [63:0] out_port, in_port;

   int n_cmp = 0;
   int n_bad = 0;

   pipemem_mmio dut (
      .clock      (clock),
      .clrn       (clrn),
      .mwmem      (mwmem),
      .mrmem      (mrmem),
      .msize      (msize),
      .munsigned  (munsigned),
      .mAlu       (mAlu),
      .mB         (mB),
      .wmo        (wmo),
      .misalign   (misalign),
      .out_port   (out_port),
      .out_strobe (out_strobe),
      .in_port    (in_port),
      .in_irq     (in_irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one MEM-cycle operation, then step past the edge that ends it.
   task automatic op(input logic w, input logic r, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
      mwmem     = w;
      mrmem     = r;
      msize     = sz;
      munsigned = u;
      mAlu      = a;
      mB        = d;
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      op(1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      clrn = 1'b0;
      in_port = '0;
      idle();
      idle();
      check("rst_wmo", wmo, 0);
      check("rst_misalign", misalign, 0);
      check("rst_out_port", out_port, 0);
      check("rst_out_strobe", out_strobe, 0);
      check("rst_in_irq", in_irq, 0);
      clrn = 1'b1;

      op(1, 0, W, 0, 32'h04, 32'h80FF7F01);
      check("sw_wmo0", wmo, 0);
      op(0, 1, B, 0, 32'h04, 0);  check("lb04", wmo, 32'h00000001);
      op(0, 1, B, 0, 32'h06, 0);  check("lb06", wmo, 32'hFFFFFFFF);
      op(0, 1, B, 0, 32'h07, 0);  check("lb07", wmo, 32'hFFFFFF80);
      op(0, 1, B, 1, 32'h07, 0);  check("lbu07", wmo, 32'h00000080);
      op(0, 1, H, 1, 32'h06, 0);  check("lhu06", wmo, 32'h000080FF);
      op(0, 1, H, 0, 32'h06, 0);  check("lh06", wmo, 32'hFFFF80FF);
      op(0, 1, B, 0, 32'h05, 0);  check("lb05", wmo, 32'h0000007F);
      idle();                     check("idle_wmo0", wmo, 0);

      op(1, 0, W, 0, 32'h08, 32'h11223344);
      op(1, 0, H, 0, 32'h0A, 32'h0000BEEF);
      op(0, 1, W, 0, 32'h08, 0);  check("lw08_sh", wmo, 32'hBEEF3344);
      op(1, 0, H, 0, 32'h09, 32'h00005555);
      check("sh09_misalign", misalign, 1);
      check("sh09_wmo", wmo, 0);
      op(0, 1, W, 0, 32'h08, 0);
      check("lw08_unchanged", wmo, 32'hBEEF3344);
      check("misalign_pulse", misalign, 0);
      op(1, 0, B, 0, 32'h09, 32'h000000AB);
      op(0, 1, W, 0, 32'h08, 0);  check("lw08_sb", wmo, 32'hBEEFAB44);
      op(0, 1, W, 0, 32'h0A, 0);
      check("lw0a_wmo", wmo, 0);
      check("lw0a_misalign", misalign, 1);

      op(1, 1, W, 0, 32'h20, 32'h0BADF00D);
      check("rw_both_wmo", wmo, 0);
      op(0, 1, W, 0, 32'h20, 0);  check("rw_both_store", wmo, 32'h0BADF00D);

      op(1, 0, W, 0, 32'h84, 32'hA5A5A5A5);
      check("out1_port", out_port, 64'hA5A5A5A5_00000000);
      check("out1_strobe", out_strobe, 2'b10);
      op(0, 1, W, 0, 32'h84, 0);
      check("out1_readback", wmo, 32'hA5A5A5A5);
      check("out1_strobe_end", out_strobe, 2'b00);
      op(1, 0, B, 0, 32'h81, 32'h0000003C);
      check("out0_byte", out_port, 64'hA5A5A5A5_00003C00);
      check("out0_strobe", out_strobe, 2'b01);
      op(1, 0, W, 0, 32'h8C, 32'hFFFFFFFF);
      check("out3_drop_port", out_port, 64'hA5A5A5A5_00003C00);
      check("out3_drop_strobe", out_strobe, 2'b00);
      op(0, 1, W, 0, 32'h8C, 0);  check("out3_read0", wmo, 0);

      in_port = 64'h00000000_00001234;
      idle();
      idle();
      check("irq_early", in_irq, 0);
      idle();
      check("irq_set", in_irq, 1);
      op(0, 1, W, 0, 32'hC0, 0);  check("in0_read", wmo, 32'h00001234);
      op(0, 1, W, 0, 32'hFC, 0);
      check("status_bit0", wmo, 32'h00000001);
      check("status_clr_irq", in_irq, 0);
      op(0, 1, W, 0, 32'hFC, 0);  check("status_cleared", wmo, 0);

      in_port = 64'h00000000_00005678;
      idle();
      in_port = 64'h00000000_00009ABC;
      idle();
      idle();
      op(0, 1, W, 0, 32'hFC, 0);
      check("status_prio_rd", wmo, 32'h00000001);
      check("status_prio_irq", in_irq, 1);
      op(0, 1, W, 0, 32'hFC, 0);
      check("status_kept", wmo, 32'h00000001);
      check("status_kept_clr", in_irq, 0);
      op(0, 1, W, 0, 32'hC0, 0);  check("in0_read2", wmo, 32'h00009ABC);
      op(0, 1, W, 0, 32'hC4, 0);  check("in1_read", wmo, 0);
      op(0, 1, W, 0, 32'hC8, 0);  check("in2_read0", wmo, 0);

      in_port = 64'h00000001_00009ABC;
      idle();
      idle();
      idle();
      check("irq_in1", in_irq, 1);
      op(1, 0, W, 0, 32'h10, 32'hCAFEF00D);
      op(0, 1, W, 0, 32'h10, 0);
      clrn = 1'b0;
      op(1, 0, W, 0, 32'h80, 32'hDEADBEEF);
      clrn = 1'b1;
      check("rst_mid_out_port", out_port, 0);
      check("rst_mid_strobe", out_strobe, 0);
      check("rst_mid_wmo", wmo, 0);
      check("rst_mid_irq", in_irq, 0);
      clrn = 1'b0;
      op(1, 0, W, 0, 32'h10, 32'h12345678);
      clrn = 1'b1;
      op(0, 1, W, 0, 32'h10, 0);  check("rst_ram_nocommit", wmo, 32'hCAFEF00D);
      clrn = 1'b0;
      op(0, 1, W, 0, 32'h10, 0);
      clrn = 1'b1;
      check("rst_load_discard", wmo, 0);

      op(1, 0, W, 0, 32'h00, 32'h11111111);
      op(1, 0, W, 0, 32'h7C, 32'h77665544);
      op(0, 1, W, 0, 32'h7C, 0);  check("wrap_raw", wmo, 32'h77665544);
      op(0, 1, W, 0, 32'h00, 0);  check("wrap_word0", wmo, 32'h11111111);
      op(0, 1, W, 0, 32'h17C, 0); check("wrap_hibits", wmo, 32'h77665544);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
